// File: rtl/debounce_pkg.sv
// Shared constants and sizing helpers for the debounce bank and its per-channel slice.
package debounce_pkg;

    localparam int DEFAULT_CLK_FREQ_KHZ = 100_000;
    localparam int DEFAULT_DEBOUNCE_MS  = 1;
    localparam int DEFAULT_HOLD_MS      = 500;
    localparam int DEFAULT_REPEAT_MS    = 100;

    function automatic int ms_to_cycles(input int khz, input int ms);
        return khz * ms;
    endfunction

    // Width that can hold every value 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounced channel: 2-flop synchroniser, stability counter, long-press counter.
// Auto-repeat of the hold pulse is built only when DEBOUNCE_BANK_REPEAT_EN is defined.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int THRESH      = 4,
    parameter int HOLD        = 20,
`ifdef DEBOUNCE_BANK_REPEAT_EN
    parameter int RPT         = 6,
`endif
    parameter bit RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic src_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic hold_o,
    output logic busy_o
);

    localparam int CW = cnt_width(THRESH);
    localparam int HW = cnt_width(HOLD);
    localparam logic [CW-1:0] CNT_LAST  = CW'(THRESH - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic          hold_q, hold_d;
    logic          first_hold_s;
    logic          rpt_hold_s;

    // Synchroniser and all channel state; async reset forces the idle level at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= RESET_LEVEL;
            sync2_q <= RESET_LEVEL;
            level_q <= RESET_LEVEL;
            cnt_q   <= '0;
            hcnt_q  <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            hold_q  <= 1'b0;
        end else begin
            sync1_q <= src_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            hcnt_q  <= hcnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            hold_q  <= hold_d;
        end
    end

    // Stability counter: any agreeing sample restarts the disagreement run.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            cnt_d   = '0;
            rise_d  = sync2_q;
            fall_d  = ~sync2_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Long-press counter saturates at HOLD so it never wraps during a long press.
    always_comb begin
        hcnt_d = hcnt_q;
        if (!level_q) begin
            hcnt_d = '0;
        end else if (hcnt_q != HOLD_MAX) begin
            hcnt_d = hcnt_q + HW'(1);
        end else begin
            hcnt_d = hcnt_q;
        end
    end

    // A hold is suppressed if the level drops on the same edge, keeping events exclusive.
    assign first_hold_s = level_q & level_d & (hcnt_q == HOLD_LAST);

`ifdef DEBOUNCE_BANK_REPEAT_EN
    localparam int RW = cnt_width(RPT);
    localparam logic [RW-1:0] RPT_LAST = RW'(RPT - 1);

    logic [RW-1:0] rcnt_q, rcnt_d;

    // Repeat counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt_q <= '0;
        end else begin
            rcnt_q <= rcnt_d;
        end
    end

    // Repeat counter runs only once the first hold has fired; reloads on each repeat.
    always_comb begin
        rcnt_d     = rcnt_q;
        rpt_hold_s = 1'b0;
        if (!level_q || (hcnt_q != HOLD_MAX)) begin
            rcnt_d = '0;
        end else if (rcnt_q == RPT_LAST) begin
            rcnt_d     = '0;
            rpt_hold_s = level_d;
        end else begin
            rcnt_d = rcnt_q + RW'(1);
        end
    end
`else
    assign rpt_hold_s = 1'b0;
`endif

    assign hold_d  = first_hold_s | rpt_hold_s;

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
    assign hold_o  = hold_q;
    assign busy_o  = sync2_q ^ level_q;

endmodule

// File: rtl/debounce_bank.sv
// N_CH-channel debouncer with rise/fall/hold event pulses and a shared busy flag.
// Optional auto-repeat of hold is enabled by defining DEBOUNCE_BANK_REPEAT_EN.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int CLK_FREQ_KHZ = DEFAULT_CLK_FREQ_KHZ,
    parameter int DEBOUNCE_MS  = DEFAULT_DEBOUNCE_MS,
    parameter int HOLD_MS      = DEFAULT_HOLD_MS,
    parameter int REPEAT_MS    = DEFAULT_REPEAT_MS,
    parameter bit RESET_LEVEL  = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] src,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic [N_CH-1:0] hold,
    output logic            busy
);

    localparam int THRESH = ms_to_cycles(CLK_FREQ_KHZ, DEBOUNCE_MS);
    localparam int HOLD   = ms_to_cycles(CLK_FREQ_KHZ, HOLD_MS);
    localparam int RPT    = ms_to_cycles(CLK_FREQ_KHZ, REPEAT_MS);
`ifdef DEBOUNCE_BANK_REPEAT_EN
    localparam bit REPEAT_EN = 1'b1;
`else
    localparam bit REPEAT_EN = 1'b0;
`endif

    // Counter widths assume THRESH >= 1 and HOLD >= 2; refuse to elaborate otherwise.
    if ((THRESH < 1) || (HOLD < 2) || (REPEAT_EN && (RPT < 1))) begin : g_bad_cfg
        $error("debounce_bank: THRESH must be >= 1, HOLD >= 2, RPT >= 1");
    end

    logic [N_CH-1:0] busy_s;

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        debounce_chan #(
            .THRESH      (THRESH),
            .HOLD        (HOLD),
`ifdef DEBOUNCE_BANK_REPEAT_EN
            .RPT         (RPT),
`endif
            .RESET_LEVEL (RESET_LEVEL)
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .src_i   (src[i]),
            .level_o (level[i]),
            .rise_o  (rise[i]),
            .fall_o  (fall[i]),
            .hold_o  (hold[i]),
            .busy_o  (busy_s[i])
        );
    end

    assign busy = |busy_s;

endmodule
